// File: rtl/rr_grant_sel.sv
// rr_grant_sel: round-robin arbiter over 8 requesters feeding a 3-to-8
// one-hot decoder. It holds each grant until release, withdrawal or hold
// timeout, then forces one idle cycle so the decoder output never moves
// straight from one requester to another.
module rr_grant_sel #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] number,
  output logic       en,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  state_e           state_q, state_d;
  logic [2:0]       number_q, number_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             en_q, en_d;
  logic             timeout_q, timeout_d;

  logic             win_vld;
  logic [2:0]       win_idx;
  logic [2:0]       scan_idx;
  logic             rel, wdraw, expire;

  // Rotating priority scan: walk offsets from far to near so the requester
  // closest to ptr (inclusive) is the last one written and wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = ptr_q;
    scan_idx = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      scan_idx = ptr_q + 3'(i);
      if (req[scan_idx]) begin
        win_vld = 1'b1;
        win_idx = scan_idx;
      end
    end
  end

  // Exit causes while granted; timeout only counts when the others are absent.
  always_comb begin
    rel    = done;
    wdraw  = !req[number_q];
    expire = (HOLD_MAX != 0) && (hold_cnt_q == HOLD_LIM);
  end

  // Next-state logic: arbitrate in IDLE, hold/exit in GRANT.
  always_comb begin
    state_d    = state_q;
    number_d   = number_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    en_d       = en_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          number_d   = win_idx;
          en_d       = 1'b1;
          hold_cnt_d = CNT_W'(1);
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (rel || wdraw || expire) begin
          en_d       = 1'b0;
          ptr_d      = number_q + 3'd1;
          hold_cnt_d = '0;
          state_d    = IDLE;
          timeout_d  = expire && !rel && !wdraw;
        end else if (HOLD_MAX != 0 && hold_cnt_q != HOLD_LIM) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the grant asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      number_q   <= 3'd0;
      ptr_q      <= 3'd0;
      hold_cnt_q <= '0;
      en_q       <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      number_q   <= number_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      en_q       <= en_d;
      timeout_q  <= timeout_d;
    end
  end

  assign number  = number_q;
  assign en      = en_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_grant_sel.sv
// Directed bench for rr_grant_sel: inputs change and outputs are sampled
// 1ns after each rising edge.
module tb_rr_grant_sel;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [2:0] number;
  logic       en;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_grant_sel #(.HOLD_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .number(number), .en(en), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #2;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = 8'h00; done = 1'b0; rst_n = 1'b0;
    #3;
    checks++;
    if (en !== 1'b0 || number !== 3'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset: en=%b number=%0d timeout=%b want 0/0/0", en, number, timeout);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: en=%b want 0", en);
    end
  endtask

  task automatic test_single_done();
    req = 8'b0000_0100;
    for (int c = 1; c <= 3; c++) begin
      step();
      checks++;
      if (en !== 1'b1 || number !== 3'd2) begin
        errors++;
        $display("FAIL single_hold%0d: en=%b number=%0d want 1/2", c, en, number);
      end
    end
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (en !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_gap: en=%b timeout=%b want 0/0", en, timeout);
    end
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd2) begin
      errors++;
      $display("FAIL single_regrant: en=%b number=%0d want 1/2", en, number);
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (en !== 1'b1 || number !== 3'(k % 8)) begin
        errors++;
        $display("FAIL rr_grant%0d: en=%b number=%0d want 1/%0d", k, en, number, k % 8);
      end
      done = 1'b1;
      step();
      done = 1'b0;
      checks++;
      if (en !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: en=%b want 0", k, en);
      end
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 15; c++) begin
      step();
      checks++;
      if (en !== 1'b1 || number !== 3'd3 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL to_hold%0d: en=%b number=%0d timeout=%b want 1/3/0", c, en, number, timeout);
      end
    end
    step();
    checks++;
    if (en !== 1'b0 || timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_pulse: en=%b timeout=%b want 0/1", en, timeout);
    end
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd3 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_regrant: en=%b number=%0d timeout=%b want 1/3/0", en, number, timeout);
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 8'h21;
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd0) begin
      errors++;
      $display("FAIL wd_grant: en=%b number=%0d want 1/0", en, number);
    end
    req = 8'h20;
    step();
    checks++;
    if (en !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_drop: en=%b timeout=%b want 0/0", en, timeout);
    end
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd5 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_next: en=%b number=%0d timeout=%b want 1/5/0", en, number, timeout);
    end
    req = 8'h00;
    step();
    checks++;
    if (en !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_end: en=%b timeout=%b want 0/0", en, timeout);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 15; c++) step();
    done = 1'b1;
    step();
    done = 1'b0;
    checks++;
    if (en !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL sim_done_at_max: en=%b timeout=%b want 0/0", en, timeout);
    end
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd3) begin
      errors++;
      $display("FAIL sim_regrant: en=%b number=%0d want 1/3", en, number);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (en !== 1'b0 || number !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b number=%0d want 0/0", en, number);
    end
    req = 8'h00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle_done();
    req = 8'h40;
    step();
    checks++;
    if (en !== 1'b1 || number !== 3'd6) begin
      errors++;
      $display("FAIL idle_setup: en=%b number=%0d want 1/6", en, number);
    end
    done = 1'b1;
    req  = 8'h00;
    step();
    for (int c = 0; c < 4; c++) begin
      done = (c % 2 == 0);
      step();
      checks++;
      if (en !== 1'b0 || number !== 3'd6 || timeout !== 1'b0) begin
        errors++;
        $display("FAIL idle_done%0d: en=%b number=%0d timeout=%b want 0/6/0", c, en, number, timeout);
      end
    end
    done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_done();
    test_round_robin();
    test_timeout();
    test_withdraw();
    test_simultaneous();
    test_idle_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
